// File: rtl/lzc_norm_if.sv
// Start/done handshake and result bus between a requester and the lzc_norm scanner.
interface lzc_norm_if #(
    parameter int WIDTH = 32
);
    localparam int PW = $clog2(WIDTH);
    localparam int LW = $clog2(WIDTH + 1);

    logic             start;
    logic [WIDTH-1:0] d;
    logic             busy;
    logic             done;
    logic [PW-1:0]    out;
    logic [LW-1:0]    lzc;
    logic             A;
    logic [WIDTH-1:0] norm;

    modport master (output start, d, input busy, done, out, lzc, A, norm);
    modport slave  (input start, d, output busy, done, out, lzc, A, norm);
endinterface

// File: rtl/lzc_norm.sv
// Multi-cycle leading-one detector and normaliser: scans one CHUNK-bit slice per
// clock from the MSB side, then reports index, leading-zero count and shifted operand.
//
//   state | meaning
//   IDLE  | waiting for start; results from the last completion are held
//   SCAN  | examining slice r_k of the captured operand
module lzc_norm #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic       clk,
    input  logic       rst,
    lzc_norm_if.slave  bus
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int PW  = $clog2(WIDTH);
    localparam int LW  = $clog2(WIDTH + 1);
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int JW  = (CHUNK > 1) ? $clog2(CHUNK) : 1;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t           r_state;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_op;
    logic             r_busy;
    logic             r_done;
    logic             r_a;
    logic [PW-1:0]    r_out;
    logic [LW-1:0]    r_lzc;
    logic [WIDTH-1:0] r_norm;

    logic [CHUNK-1:0] w_slice;
    logic [JW-1:0]    w_j;
    logic             w_hit;
    logic [PW-1:0]    w_out;
    logic [LW-1:0]    w_lzc;

    // Slice select as a constant-index mux, so no variable-width shifter is built.
    always_comb begin
        w_slice = '0;
        for (int c = 0; c < NCH; c++) begin
            if (r_k == KW'(c))
                w_slice = r_op[WIDTH-1-CHUNK*c -: CHUNK];
        end
    end

    always_comb begin
        w_j = '0;
        for (int j = 0; j < CHUNK; j++) begin
            if (w_slice[j])
                w_j = JW'(j);
        end
        w_hit = |w_slice;
        w_out = PW'(WIDTH - CHUNK * (int'(r_k) + 1) + int'(w_j));
        w_lzc = LW'(CHUNK * int'(r_k) + CHUNK - 1 - int'(w_j));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_op    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_a     <= 1'b0;
            r_out   <= '0;
            r_lzc   <= '0;
            r_norm  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_op    <= bus.d;
                        r_k     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_hit) begin
                        r_out   <= w_out;
                        r_lzc   <= w_lzc;
                        r_norm  <= r_op << w_lzc;
                        r_a     <= 1'b0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (r_k == KW'(NCH - 1)) begin
                        r_out   <= '0;
                        r_lzc   <= LW'(WIDTH);
                        r_norm  <= '0;
                        r_a     <= 1'b1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.out  = r_out;
    assign bus.lzc  = r_lzc;
    assign bus.A    = r_a;
    assign bus.norm = r_norm;
endmodule

// File: tb/tb_lzc_norm.sv
// Bench for lzc_norm: directed vector table, handshake/reset sequences, a 24-bit
// instance, and a random sweep over several CHUNK sizes against a reference model.
module tb_lzc_norm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    lzc_norm_if #(.WIDTH(32)) bm ();
    lzc_norm_if #(.WIDTH(32)) b1 ();
    lzc_norm_if #(.WIDTH(32)) b4 ();
    lzc_norm_if #(.WIDTH(32)) b32 ();
    lzc_norm_if #(.WIDTH(24)) b24 ();

    lzc_norm #(.WIDTH(32), .CHUNK(8))  u_main (.clk(clk), .rst(rst), .bus(bm.slave));
    lzc_norm #(.WIDTH(32), .CHUNK(1))  u_c1   (.clk(clk), .rst(rst), .bus(b1.slave));
    lzc_norm #(.WIDTH(32), .CHUNK(4))  u_c4   (.clk(clk), .rst(rst), .bus(b4.slave));
    lzc_norm #(.WIDTH(32), .CHUNK(32)) u_c32  (.clk(clk), .rst(rst), .bus(b32.slave));
    lzc_norm #(.WIDTH(24), .CHUNK(6))  u_w24  (.clk(clk), .rst(rst), .bus(b24.slave));

    logic        sw_start = 1'b0;
    logic [31:0] sw_d = '0;
    assign b1.start  = sw_start;
    assign b1.d      = sw_d;
    assign b4.start  = sw_start;
    assign b4.d      = sw_d;
    assign b32.start = sw_start;
    assign b32.d     = sw_d;

    logic [3:0]  sw_done;
    logic [3:0]  sw_a;
    logic [4:0]  sw_out  [4];
    logic [5:0]  sw_lzc  [4];
    logic [31:0] sw_norm [4];
    assign sw_done = {b32.done, b4.done, b1.done, bm.done};
    assign sw_a    = {b32.A, b4.A, b1.A, bm.A};
    assign sw_out[0] = bm.out;   assign sw_out[1] = b1.out;
    assign sw_out[2] = b4.out;   assign sw_out[3] = b32.out;
    assign sw_lzc[0] = bm.lzc;   assign sw_lzc[1] = b1.lzc;
    assign sw_lzc[2] = b4.lzc;   assign sw_lzc[3] = b32.lzc;
    assign sw_norm[0] = bm.norm; assign sw_norm[1] = b1.norm;
    assign sw_norm[2] = b4.norm; assign sw_norm[3] = b32.norm;

    typedef struct {
        logic [31:0] d;
        int          lat;
        int          out;
        int          lzc;
        logic        a;
        logic [31:0] norm;
    } vec_t;

    localparam int NV = 10;
    vec_t tv [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int ref_lzc(input logic [31:0] v);
        for (int i = 31; i >= 0; i--)
            if (v[i]) return 31 - i;
        return 32;
    endfunction

    task automatic start_main(input logic [31:0] dv);
        @(negedge clk);
        bm.start = 1'b1;
        bm.d     = dv;
        @(posedge clk);
        #1;
        bm.start = 1'b0;
    endtask

    task automatic wait_main(input int base, output int lat);
        lat = base;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bm.done) return;
        end
        lat = -1;
    endtask

    task automatic run24(input logic [23:0] dv, input int elat, input int eout,
                         input int elzc, input logic ea, input logic [23:0] enorm);
        int lat;
        @(negedge clk);
        b24.start = 1'b1;
        b24.d     = dv;
        @(posedge clk);
        #1;
        b24.start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (b24.done) begin
                lat = c;
                break;
            end
        end
        check($sformatf("w24 %h lat", dv), 64'(lat), 64'(elat));
        check($sformatf("w24 %h out", dv), 64'(b24.out), 64'(eout));
        check($sformatf("w24 %h lzc", dv), 64'(b24.lzc), 64'(elzc));
        check($sformatf("w24 %h A", dv), 64'(b24.A), 64'(ea));
        check($sformatf("w24 %h norm", dv), 64'(b24.norm), 64'(enorm));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int chunks [4];
        int got_lat [4];
        logic [31:0] got_out [4];
        logic [31:0] got_lzc [4];
        logic [31:0] got_norm [4];
        logic [3:0]  got_a;

        chunks = '{8, 1, 4, 32};
        tv[0] = '{32'h8000_0000, 1, 31,  0, 1'b0, 32'h8000_0000};
        tv[1] = '{32'h0001_0000, 2, 16, 15, 1'b0, 32'h8000_0000};
        tv[2] = '{32'h0000_0F00, 3, 11, 20, 1'b0, 32'hF000_0000};
        tv[3] = '{32'h0000_0001, 4,  0, 31, 1'b0, 32'h8000_0000};
        tv[4] = '{32'h0000_0000, 4,  0, 32, 1'b1, 32'h0000_0000};
        tv[5] = '{32'h4000_0000, 1, 30,  1, 1'b0, 32'h8000_0000};
        tv[6] = '{32'h0080_0000, 2, 23,  8, 1'b0, 32'h8000_0000};
        tv[7] = '{32'h0001_2345, 2, 16, 15, 1'b0, 32'h91A2_8000};
        tv[8] = '{32'h0100_0000, 1, 24,  7, 1'b0, 32'h8000_0000};
        tv[9] = '{32'h0000_00FF, 4,  7, 24, 1'b0, 32'hFF00_0000};

        bm.start  = 1'b0;
        bm.d      = '0;
        b24.start = 1'b0;
        b24.d     = '0;

        #1;
        check("reset busy", 64'(bm.busy), 64'(0));
        check("reset done", 64'(bm.done), 64'(0));
        check("reset out",  64'(bm.out),  64'(0));
        check("reset lzc",  64'(bm.lzc),  64'(0));
        check("reset A",    64'(bm.A),    64'(0));
        check("reset norm", 64'(bm.norm), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            start_main(tv[i].d);
            wait_main(0, lat);
            check($sformatf("vec%0d lat", i),  64'(lat),     64'(tv[i].lat));
            check($sformatf("vec%0d out", i),  64'(bm.out),  64'(tv[i].out));
            check($sformatf("vec%0d lzc", i),  64'(bm.lzc),  64'(tv[i].lzc));
            check($sformatf("vec%0d A", i),    64'(bm.A),    64'(tv[i].a));
            check($sformatf("vec%0d norm", i), 64'(bm.norm), 64'(tv[i].norm));
            check($sformatf("vec%0d busy", i), 64'(bm.busy), 64'(0));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d done pulse", i), 64'(bm.done), 64'(0));
        end

        // Start while busy is ignored; held results survive the new acceptance.
        start_main(32'h0000_0001);
        check("hold lzc on start", 64'(bm.lzc), 64'(tv[NV-1].lzc));
        check("hold out on start", 64'(bm.out), 64'(tv[NV-1].out));
        @(negedge clk);
        bm.start = 1'b1;
        bm.d     = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        bm.start = 1'b0;
        check("ignored busy", 64'(bm.busy), 64'(1));
        wait_main(1, lat);
        check("ignored lat", 64'(lat),    64'(4));
        check("ignored out", 64'(bm.out), 64'(0));
        check("ignored lzc", 64'(bm.lzc), 64'(31));
        @(posedge clk);
        #1;
        check("ignored no requeue", 64'(bm.busy), 64'(0));

        // Start raised in the done cycle is accepted on the following edge.
        start_main(32'h8000_0000);
        wait_main(0, lat);
        check("b2b first lat", 64'(lat), 64'(1));
        bm.start = 1'b1;
        bm.d     = 32'h0000_0F00;
        @(posedge clk);
        #1;
        bm.start = 1'b0;
        check("b2b accepted", 64'(bm.busy), 64'(1));
        wait_main(0, lat);
        check("b2b lat",  64'(lat),     64'(3));
        check("b2b out",  64'(bm.out),  64'(11));
        check("b2b lzc",  64'(bm.lzc),  64'(20));
        check("b2b norm", 64'(bm.norm), 64'(32'hF000_0000));

        // Asynchronous reset in the middle of a scan.
        start_main(32'h0000_0001);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst busy", 64'(bm.busy), 64'(0));
        check("midrst done", 64'(bm.done), 64'(0));
        check("midrst out",  64'(bm.out),  64'(0));
        check("midrst lzc",  64'(bm.lzc),  64'(0));
        check("midrst A",    64'(bm.A),    64'(0));
        check("midrst norm", 64'(bm.norm), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("midrst no done c%0d", c), 64'(bm.done | bm.busy), 64'(0));
        end
        start_main(32'h4000_0000);
        wait_main(0, lat);
        check("postrst lat", 64'(lat),    64'(1));
        check("postrst out", 64'(bm.out), 64'(30));
        check("postrst lzc", 64'(bm.lzc), 64'(1));

        run24(24'h000800, 3, 11, 12, 1'b0, 24'h800000);
        run24(24'h000001, 4,  0, 23, 1'b0, 24'h800000);
        run24(24'h000000, 4,  0, 24, 1'b1, 24'h000000);
        run24(24'hC00000, 1, 23,  0, 1'b0, 24'hC00000);

        // Random sweep: all 32-bit instances get the same operand concurrently.
        for (int it = 0; it < 40; it++) begin
            logic [31:0] v;
            int sh, el, eo;
            logic [31:0] en;
            v  = $urandom;
            sh = $urandom_range(0, 32);
            v  = (sh == 32) ? 32'h0 : (v >> sh);
            el = ref_lzc(v);
            eo = (el == 32) ? 0 : 31 - el;
            en = (el == 32) ? 32'h0 : (v << el);
            @(negedge clk);
            sw_start = 1'b1;
            sw_d     = v;
            bm.start = 1'b1;
            bm.d     = v;
            @(posedge clk);
            #1;
            sw_start = 1'b0;
            bm.start = 1'b0;
            for (int x = 0; x < 4; x++) got_lat[x] = -1;
            for (int c = 1; c <= 40; c++) begin
                @(posedge clk);
                #1;
                for (int x = 0; x < 4; x++) begin
                    if (sw_done[x] && got_lat[x] < 0) begin
                        got_lat[x]  = c;
                        got_out[x]  = 32'(sw_out[x]);
                        got_lzc[x]  = 32'(sw_lzc[x]);
                        got_norm[x] = sw_norm[x];
                        got_a[x]    = sw_a[x];
                    end
                end
                if (got_lat[0] > 0 && got_lat[1] > 0 && got_lat[2] > 0 && got_lat[3] > 0)
                    break;
            end
            for (int x = 0; x < 4; x++) begin
                int elat;
                elat = (el == 32) ? 32 / chunks[x] : el / chunks[x] + 1;
                check($sformatf("rnd%0d c%0d lat", it, chunks[x]), 64'(got_lat[x]), 64'(elat));
                if (got_lat[x] > 0) begin
                    check($sformatf("rnd%0d c%0d out d=%h", it, chunks[x], v), 64'(got_out[x]), 64'(eo));
                    check($sformatf("rnd%0d c%0d lzc d=%h", it, chunks[x], v), 64'(got_lzc[x]), 64'(el));
                    check($sformatf("rnd%0d c%0d A d=%h", it, chunks[x], v), 64'(got_a[x]), 64'(el == 32));
                    check($sformatf("rnd%0d c%0d norm d=%h", it, chunks[x], v), 64'(got_norm[x]), 64'(en));
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/lzc_norm.md
# lzc_norm

Parametrised, multi-cycle leading-one detector and normaliser for the floating-point adder datapath. It scans a WIDTH-bit operand from the MSB side one CHUNK-bit slice per clock and reports the following:
- the index of the highest set bit;
- the leading-zero count;
- an all-zero flag;
- the operand left-shifted so that its MSB is 1.

Compared with the single-cycle 32-bit priority encoder, it trades latency for area, supports arbitrary widths (mantissa widths 24/53 included) and adds a start/done handshake.

## Interface
- WIDTH, 32, operand width; must be an integer multiple of CHUNK and at least 2.
- CHUNK, 8, slice width examined per cycle; 1 ≤ CHUNK ≤ WIDTH.
- Derived values:
  - NCH = WIDTH/CHUNK.
  - PW = $clog2(WIDTH).
  - LW = $clog2(WIDTH+1).

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; accepted only when busy=0.
- d  in  WIDTH  operand; sampled on the accepting edge only.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse; results valid from this cycle.
- out  out  PW  bit index of the highest set bit of the captured operand.
- lzc  out  LW  leading-zero count, WIDTH-1-out; equals WIDTH when the operand is zero.
- A  out  1  operand was all zero.
- norm  out  WIDTH  captured operand << lzc; 0 when A=1.

## Operation
- **States.** The FSM has two states, IDLE and SCAN. A chunk counter k runs from 0 to NCH-1, where k=0 is bits [WIDTH-1:WIDTH-CHUNK].
- **IDLE.**
  - start=1 on an edge: capture d into the operand register, set k=0, enter SCAN, set busy=1.
  - start=0: remain in IDLE.
- **SCAN.** Each cycle, slice k of the captured operand goes through a CHUNK-wide priority encoder, MSB first.
  - Slice nonzero, with local index j of the highest 1:
    - register out = WIDTH-CHUNK*(k+1)+j;
    - register lzc = CHUNK*k + (CHUNK-1-j);
    - register norm = operand << lzc;
    - register A=0, done=1, busy=0;
    - return to IDLE.
  - Slice zero and k<NCH-1: k←k+1.
  - Slice zero and k=NCH-1: register A=1, out=0, lzc=WIDTH, norm=0, done=1, busy=0; return to IDLE.
- **start while busy=1:** ignored. The operand register is not disturbed, and the request is not queued.
- **Result hold:** out, lzc, A and norm hold their values until the next completion or reset. They do not change on start.
- **Shift width:** the norm shift is a full-width logical left shift. Bits shifted out are discarded and zeros fill from the LSB side.

## Timing
- **Reset values** (immediately on rst, independent of clk):
  - state=IDLE, k=0;
  - busy=0, done=0;
  - out=0, lzc=0, A=0, norm=0.
- **Latency:** with start accepted at edge E0 and the first nonzero slice at k, done=1 and busy=0 after edge E0+k+1.
  - All-zero operand: done after E0+NCH.
  - Minimum latency is 1 cycle; maximum is NCH cycles.
- **done:** high for exactly one cycle.
- **Back-to-back:** start may be high in the done cycle. It is accepted on the following edge, giving a throughput of one operation per (latency+1) cycles at best.
- **Reset mid-scan:** the operation is aborted, no done is produced, and all outputs return to their reset values.
- **Reset deassertion:** the first start is sampled on the first rising edge with rst=0.
- **Boundary case, d=1 with bit 0 in the last slice:** maximum latency with A=0, lzc=WIDTH-1 and norm=1<<(WIDTH-1).

## Test plan
1. WIDTH=32, CHUNK=8, start with d=0x80000000 -> done 1 cycle after the accepting edge; out=31, lzc=0, A=0, norm=0x80000000.
2. d=0x00010000 -> done after 2 cycles; out=16, lzc=15, norm=0x80000000. Then d=0x00000F00 -> done after 3 cycles; out=11, lzc=20, norm=0xF0000000.
3. Boundary cases:
   - d=0x00000001 -> done after 4 cycles; out=0, lzc=31, norm=0x80000000.
   - d=0 -> done after 4 cycles; A=1, lzc=32, out=0, norm=0.
4. Handshake:
   - Start d=0x00000001, then pulse start with d=0xFFFFFFFF at cycle 2 -> second request ignored; result is still out=0, lzc=31.
   - Start asserted in the done cycle -> accepted next edge; second result correct.
5. Reset behaviour:
   - Assert rst asynchronously mid-scan of d=0x00000001 -> busy, done and all outputs return to 0 immediately; no done pulse follows.
   - Next start with d=0x40000000 gives out=30, lzc=1.
6. WIDTH=24, CHUNK=6: d=0x000800 -> done after 3 cycles; out=11, lzc=12, norm=0x800000. Also run a randomised sweep against a reference model for CHUNK ∈ {1,4,8,32}.
